// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect, memory waits, CSR drain.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush perf counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [1:0]       id_dep_check,
  input  logic             id_csr,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_stall,
  output logic             de_flush,
  output logic             em_stall,
  output logic             mw_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    SERIALIZE = 2'd2,
    CSR_ISSUE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  state_t        prev_q, prev_d;
  state_t        cur_state;
  logic [DW-1:0] drain_q, drain_d;

  logic hit_rs1, hit_rs2, load_use;
  logic pc_stall_c, fd_stall_c, fd_flush_c, de_stall_c, de_flush_c, em_stall_c, mw_stall_c;

  // MEM_WAIT is transparent once dmem_busy drops: act as the state it interrupted.
  always_comb begin
    cur_state = state_q;
    if (state_q == MEM_WAIT) begin
      cur_state = prev_q;
    end
  end

  always_comb begin
    hit_rs1  = id_dep_check[0] && (id_rs1 == ex_rd);
    hit_rs2  = id_dep_check[1] && (id_rs2 == ex_rd);
    load_use = ex_load && (ex_rd != 5'd0) && (hit_rs1 || hit_rs2);
  end

  always_comb begin
    pc_stall_c = 1'b0;
    fd_stall_c = 1'b0;
    fd_flush_c = 1'b0;
    de_stall_c = 1'b0;
    de_flush_c = 1'b0;
    em_stall_c = 1'b0;
    mw_stall_c = 1'b0;
    state_d    = state_q;
    prev_d     = prev_q;
    drain_d    = drain_q;

    if (dmem_busy) begin
      pc_stall_c = 1'b1;
      fd_stall_c = 1'b1;
      de_stall_c = 1'b1;
      em_stall_c = 1'b1;
      mw_stall_c = 1'b1;
      state_d    = MEM_WAIT;
      prev_d     = cur_state;
    end else if (ex_branch_taken) begin
      // Any CSR op being drained is younger than the branch, so it is squashed too.
      fd_flush_c = 1'b1;
      de_flush_c = 1'b1;
      state_d    = RUN;
      drain_d    = '0;
    end else begin
      unique case (cur_state)
        RUN: begin
          state_d = RUN;
          if (id_csr) begin
            pc_stall_c = 1'b1;
            fd_stall_c = 1'b1;
            de_flush_c = 1'b1;
            drain_d    = DRAIN_LOAD;
            state_d    = (DRAIN_CYCLES <= 1) ? CSR_ISSUE : SERIALIZE;
          end else if (load_use) begin
            pc_stall_c = 1'b1;
            fd_stall_c = 1'b1;
            de_flush_c = 1'b1;
          end else if (imem_busy) begin
            pc_stall_c = 1'b1;
            fd_flush_c = 1'b1;
          end
        end
        SERIALIZE: begin
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_flush_c = 1'b1;
          if (drain_q <= DW'(1)) begin
            drain_d = '0;
            state_d = CSR_ISSUE;
          end else begin
            drain_d = drain_q - DW'(1);
            state_d = SERIALIZE;
          end
        end
        CSR_ISSUE: begin
          pc_stall_c = 1'b1;
          fd_flush_c = 1'b1;
          drain_d    = '0;
          state_d    = RUN;
        end
        default: begin
          state_d = RUN;
          drain_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RUN;
      prev_q  <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      drain_q <= drain_d;
    end
  end

  // Controls are forced low while reset is asserted, independent of the hazard inputs.
  assign pc_stall = nrst & pc_stall_c;
  assign fd_stall = nrst & fd_stall_c;
  assign fd_flush = nrst & fd_flush_c;
  assign de_stall = nrst & de_stall_c;
  assign de_flush = nrst & de_flush_c;
  assign em_stall = nrst & em_stall_c;
  assign mw_stall = nrst & mw_stall_c;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_c && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((fd_flush_c || de_flush_c) && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl against a cycle-count model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int DRAIN = 3;
  localparam int CW    = 32;
`ifdef HAZ_PERF_CNT_EN
  localparam logic [31:0] IMEM_WAIT_STALLS = 32'd2;
`else
  localparam logic [31:0] IMEM_WAIT_STALLS = 32'd0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic [1:0] id_dep_check = '0;
  logic id_csr = 1'b0, ex_load = 1'b0, ex_branch_taken = 1'b0;
  logic imem_busy = 1'b0, dmem_busy = 1'b0;
  logic pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_stall;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [6:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_dep_check(id_dep_check), .id_csr(id_csr),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_branch_taken(ex_branch_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
    .de_stall(de_stall), .de_flush(de_flush), .em_stall(em_stall), .mw_stall(mw_stall),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_stall}
  assign dut_vec = {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_stall};

  // Model: remaining CSR hold cycles, a pending issue cycle, and the perf totals.
  int            m_drain = 0;
  bit            m_issue = 1'b0;
  logic [CW-1:0] m_stall_cnt = '0;
  logic [CW-1:0] m_flush_cnt = '0;
  logic [6:0]    m_o;
  logic [6:0]    e_vec;

  function automatic logic [6:0] model_out();
    logic lu;
    lu = ex_load && (ex_rd != 5'd0) &&
         ((id_dep_check[0] && id_rs1 == ex_rd) || (id_dep_check[1] && id_rs2 == ex_rd));
    if (!nrst)           return 7'b0000000;
    if (dmem_busy)       return 7'b1101011;
    if (ex_branch_taken) return 7'b0010100;
    if (m_drain > 0)     return 7'b1100100;
    if (m_issue)         return 7'b1010000;
    if (id_csr || lu)    return 7'b1100100;
    if (imem_busy)       return 7'b1010000;
    return 7'b0000000;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_drain     <= 0;
      m_issue     <= 1'b0;
      m_stall_cnt <= '0;
      m_flush_cnt <= '0;
    end else begin
      m_o = model_out();
      if (m_o[6] && m_stall_cnt != '1) m_stall_cnt <= m_stall_cnt + 1;
      if ((m_o[4] || m_o[2]) && m_flush_cnt != '1) m_flush_cnt <= m_flush_cnt + 1;
      if (dmem_busy) begin
      end else if (ex_branch_taken) begin
        m_drain <= 0;
        m_issue <= 1'b0;
      end else if (m_drain > 0) begin
        m_drain <= m_drain - 1;
        m_issue <= (m_drain == 1);
      end else if (m_issue) begin
        m_issue <= 1'b0;
      end else if (id_csr) begin
        m_drain <= DRAIN - 1;
        m_issue <= (DRAIN == 1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    e_vec = model_out();
    chk("model_ctrl", 32'(dut_vec), 32'(e_vec));
`ifdef HAZ_PERF_CNT_EN
    chk("model_stall_cnt", stall_cycles, m_stall_cnt);
    chk("model_flush_cnt", flush_events, m_flush_cnt);
`else
    chk("stall_cnt_tied", stall_cycles, 32'd0);
    chk("flush_cnt_tied", flush_events, 32'd0);
`endif
  end

  // Check the current cycle against a hand-computed literal, then advance one clock.
  task automatic cyc(input string name, input logic [6:0] exp);
    @(negedge clk);
    chk(name, 32'(dut_vec), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem_busy = 1'b1; ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_dep_check = 2'b01;
    cyc("reset_a", 7'b0000000);
    cyc("reset_b", 7'b0000000);
    nrst = 1'b1; imem_busy = 1'b0;
    cyc("lu_rs1", 7'b1100100);
    ex_load = 1'b0;
    cyc("lu_bubble", 7'b0000000);

    ex_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_dep_check = 2'b10;
    cyc("lu_rs2", 7'b1100100);
    id_dep_check = 2'b01;
    cyc("lu_rs2_unused", 7'b0000000);
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_dep_check = 2'b11;
    cyc("x0_nodep", 7'b0000000);

    ex_rd = 5'd5; id_rs1 = 5'd5; id_dep_check = 2'b01; ex_branch_taken = 1'b1;
    cyc("br_over_lu", 7'b0010100);
    ex_branch_taken = 1'b0; ex_load = 1'b0;

    id_csr = 1'b1;
    cyc("csr_hold1", 7'b1100100);
    cyc("csr_hold2", 7'b1100100);
    cyc("csr_hold3", 7'b1100100);
    id_csr = 1'b0;
    cyc("csr_issue", 7'b1010000);
    cyc("csr_run", 7'b0000000);

    id_csr = 1'b1;
    cyc("csrm_hold1", 7'b1100100);
    cyc("csrm_hold2", 7'b1100100);
    dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc("csrm_dmem", 7'b1101011);
    dmem_busy = 1'b0;
    cyc("csrm_resume", 7'b1100100);
    id_csr = 1'b0;
    cyc("csrm_issue", 7'b1010000);
    cyc("csrm_run", 7'b0000000);

    id_csr = 1'b1;
    cyc("abort_hold", 7'b1100100);
    ex_branch_taken = 1'b1;
    cyc("abort_br", 7'b0010100);
    ex_branch_taken = 1'b0; id_csr = 1'b0;
    cyc("abort_run_a", 7'b0000000);
    cyc("abort_run_b", 7'b0000000);

    dmem_busy = 1'b1; ex_branch_taken = 1'b1; imem_busy = 1'b1;
    cyc("dmem_over_br", 7'b1101011);
    dmem_busy = 1'b0; ex_branch_taken = 1'b0;
    cyc("imem_run", 7'b1010000);
    imem_busy = 1'b0;

    nrst = 1'b0;
    cyc("perf_clear", 7'b0000000);
    nrst = 1'b1; imem_busy = 1'b1;
    cyc("imem_a", 7'b1010000);
    cyc("imem_b", 7'b1010000);
    imem_busy = 1'b0; id_csr = 1'b1;
    @(negedge clk);
    chk("perf_imem_stalls", stall_cycles, IMEM_WAIT_STALLS);
    cyc("rcsr_hold1", 7'b1100100);
    cyc("rcsr_hold2", 7'b1100100);
    nrst = 1'b0;
    #2;
    chk("rst_async_ctrl", 32'(dut_vec), 32'd0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    cyc("rst_mid_ser", 7'b0000000);
    nrst = 1'b1; id_csr = 1'b0;
    cyc("post_rst_a", 7'b0000000);
    cyc("post_rst_b", 7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
